// File: rtl/doodle_physics.sv
// Per-frame doodle motion engine: input/gravity, one-slot-per-cycle platform scan, commit and camera.
// Optional macro DOODLE_WRAP_EN selects horizontal wrap-around instead of clamping at the screen edges.
module doodle_physics #(
  parameter int unsigned SCREEN_WIDTH  = 400,
  parameter int unsigned SCREEN_HEIGHT = 700,
  parameter int unsigned BLOCK_WIDTH   = 40,
  parameter int unsigned NUM_BLOCKS    = 8,
  parameter int unsigned JUMP_VELOCITY = 20,
  parameter int unsigned GRAVITY       = 1,
  parameter int unsigned MAX_FALL      = 20,
  parameter int unsigned MOVE_STEP     = 4,
  parameter int unsigned START_X       = 200,
  parameter int unsigned START_Y       = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    left,
  input  logic                    right,
  input  logic [NUM_BLOCKS*32-1:0] blocksX,
  input  logic [NUM_BLOCKS*32-1:0] blocksY,
  input  logic [NUM_BLOCKS-1:0]   isBlockActive,
  output logic [31:0]             doodleX,
  output logic [31:0]             doodleY,
  output logic [31:0]             minY,
  output logic                    busy,
  output logic                    done,
  output logic                    gameOver,
  output logic                    ascending
);

  localparam int unsigned IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);
  localparam logic [31:0] SW32    = 32'(SCREEN_WIDTH);
  localparam logic [31:0] HALF32  = 32'(SCREEN_HEIGHT / 2);
  localparam logic [31:0] BW_M1   = 32'(BLOCK_WIDTH - 1);
  localparam logic [31:0] STEP32  = 32'(MOVE_STEP);
  localparam logic [31:0] SX32    = 32'(START_X);
  localparam logic [31:0] SY32    = 32'(START_Y);
  localparam logic [15:0] JUMP16  = 16'(JUMP_VELOCITY);
  localparam logic [15:0] GRAV16  = 16'(GRAVITY);
  localparam logic [15:0] MAXF16  = 16'(MAX_FALL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_COMMIT,
    S_DEAD
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_x;
  logic [31:0]      r_y;
  logic [31:0]      r_min;
  logic             r_asc;
  logic [15:0]      r_vel;
  logic [15:0]      r_fall;
  logic [15:0]      r_fallp;
  logic [31:0]      r_newx;
  logic             r_hit;
  logic [31:0]      r_hit_y;
  logic             r_busy;
  logic             r_done;
  logic             r_go;

  logic [31:0] w_bx_arr [NUM_BLOCKS];
  logic [31:0] w_by_arr [NUM_BLOCKS];
  logic [31:0] w_bx;
  logic [31:0] w_by;
  logic        w_act;
  logic        w_hit;
  logic        w_better;
  logic [31:0] w_newx;
  logic [15:0] w_fall_inc;
  logic [15:0] w_fallp;
  logic [31:0] w_fallp32;
  logic [31:0] w_y_up;
  logic [15:0] w_vel_next;

  always_comb begin
    for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
      w_bx_arr[i] = blocksX[32*i +: 32];
      w_by_arr[i] = blocksY[32*i +: 32];
    end
  end

  always_comb begin
    w_bx  = w_bx_arr[r_idx];
    w_by  = w_by_arr[r_idx];
    w_act = isBlockActive[r_idx];
  end

`ifdef DOODLE_WRAP_EN
  always_comb begin
    w_newx = r_x;
    if (left && !right)
      w_newx = (r_x < STEP32) ? (r_x + SW32 - STEP32) : (r_x - STEP32);
    else if (right && !left)
      w_newx = (r_x + STEP32 >= SW32) ? (r_x + STEP32 - SW32) : (r_x + STEP32);
  end
`else
  always_comb begin
    w_newx = r_x;
    if (left && !right)
      w_newx = (r_x < STEP32) ? '0 : (r_x - STEP32);
    else if (right && !left)
      w_newx = r_x + STEP32;
    if (w_newx > SW32 - 32'd1)
      w_newx = SW32 - 32'd1;
  end
`endif

  always_comb begin
    w_fall_inc = r_fall + GRAV16;
    w_fallp    = (w_fall_inc > MAXF16) ? MAXF16 : w_fall_inc;
    w_fallp32  = {16'd0, r_fallp};
    w_y_up     = r_y + {16'd0, r_vel};
    w_vel_next = r_vel - GRAV16;
    // Landing window: feet currently at or above the top, and this tick's drop reaches it.
    w_hit = w_act && !r_asc &&
            (r_newx >= w_bx) && (r_newx <= w_bx + BW_M1) &&
            (w_by <= r_y) && (w_by + w_fallp32 >= r_y);
    w_better = w_hit && (!r_hit || (w_by > r_hit_y));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_x     <= SX32;
      r_y     <= SY32;
      r_min   <= '0;
      r_asc   <= 1'b1;
      r_vel   <= JUMP16;
      r_fall  <= '0;
      r_fallp <= '0;
      r_newx  <= SX32;
      r_hit   <= 1'b0;
      r_hit_y <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_go    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (tick && !r_go) begin
            r_newx  <= w_newx;
            if (!r_asc)
              r_fallp <= w_fallp;
            r_hit   <= 1'b0;
            r_hit_y <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (w_better) begin
            r_hit   <= 1'b1;
            r_hit_y <= w_by;
          end
          if (r_idx == LAST_IDX)
            r_state <= S_COMMIT;
          else
            r_idx <= r_idx + 1'b1;
        end

        S_COMMIT: begin
          r_x     <= r_newx;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (r_asc) begin
            r_y   <= w_y_up;
            r_vel <= w_vel_next;
            if (w_vel_next == '0) begin
              r_asc  <= 1'b0;
              r_fall <= '0;
            end
            if (w_y_up > r_min + HALF32)
              r_min <= w_y_up - HALF32;
          end else if (r_hit) begin
            r_y    <= r_hit_y;
            r_asc  <= 1'b1;
            r_vel  <= JUMP16;
            r_fall <= '0;
          end else if (r_y < r_min + w_fallp32) begin
            r_y     <= r_min;
            r_go    <= 1'b1;
            r_state <= S_DEAD;
          end else begin
            r_y    <= r_y - w_fallp32;
            r_fall <= r_fallp;
          end
        end

        S_DEAD: begin
          r_busy <= 1'b0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign doodleX   = r_x;
  assign doodleY   = r_y;
  assign minY      = r_min;
  assign busy      = r_busy;
  assign done      = r_done;
  assign gameOver  = r_go;
  assign ascending = r_asc;

endmodule

// File: tb/tb_doodle_physics.sv
// Bench for doodle_physics: directed vector table, hand-written corner sequences and random ticks vs a model.
module tb_doodle_physics;

  localparam int NB = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             tick = 1'b0;
  logic             left = 1'b0;
  logic             right = 1'b0;
  logic [NB*32-1:0] blocksX = '0;
  logic [NB*32-1:0] blocksY = '0;
  logic [NB-1:0]    isBlockActive = '0;
  logic [31:0]      doodleX, doodleY, minY;
  logic             busy, done, gameOver, ascending;

  doodle_physics #(.NUM_BLOCKS(NB)) dut (
    .clk(clk), .reset(reset), .tick(tick), .left(left), .right(right),
    .blocksX(blocksX), .blocksY(blocksY), .isBlockActive(isBlockActive),
    .doodleX(doodleX), .doodleY(doodleY), .minY(minY),
    .busy(busy), .done(done), .gameOver(gameOver), .ascending(ascending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  longint bxa [NB];
  longint bya [NB];
  bit     acta[NB];

  // Reference model state, signed integers with plain arithmetic
  longint m_x, m_y, m_min, m_vel, m_fall;
  bit     m_asc, m_go;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_blocks();
    for (int i = 0; i < NB; i++) begin
      blocksX[i*32 +: 32] = 32'(bxa[i]);
      blocksY[i*32 +: 32] = 32'(bya[i]);
      isBlockActive[i]    = acta[i];
    end
  endtask

  task automatic set_slot(input int i, input longint x, input longint y, input bit a);
    bxa[i] = x; bya[i] = y; acta[i] = a;
  endtask

  task automatic set_cfg(input int c);
    for (int i = 0; i < NB; i++) set_slot(i, 0, 0, 0);
    if (c == 1) begin
      set_slot(0, 190, 203, 0);
      set_slot(1, 190, 200, 1);
      set_slot(2, 180, 199, 1);
      set_slot(3, 300, 204, 1);
      set_slot(4, 160, 201, 1);
      set_slot(5, 190, 200, 1);
      set_slot(6, 200, 199, 1);
      set_slot(7, 170, 198, 1);
    end else if (c == 2) begin
      for (int i = 0; i < 5; i++) set_slot(i, 200 + 40*i, 200, 1);
    end
    drive_blocks();
  endtask

  function automatic void model_reset();
    m_x = 200; m_y = 10; m_min = 0; m_vel = 20; m_fall = 0; m_asc = 1; m_go = 0;
  endfunction

  function automatic void model_tick(input bit l, input bit r);
    longint nx, fp, best;
    if (m_go) return;
    nx = m_x;
    if (l && !r) nx = m_x - 4;
    else if (r && !l) nx = m_x + 4;
`ifdef DOODLE_WRAP_EN
    nx = (nx + 400) % 400;
`else
    if (nx < 0) nx = 0;
    if (nx > 399) nx = 399;
`endif
    if (m_asc) begin
      m_y   = m_y + m_vel;
      m_vel = m_vel - 1;
      if (m_vel == 0) begin m_asc = 0; m_fall = 0; end
      if (m_y - 350 > m_min) m_min = m_y - 350;
    end else begin
      fp = (m_fall + 1 > 20) ? 20 : m_fall + 1;
      best = -1;
      for (int i = 0; i < NB; i++)
        if (acta[i] && nx >= bxa[i] && nx <= bxa[i] + 39 &&
            bya[i] <= m_y && bya[i] + fp >= m_y && bya[i] > best)
          best = bya[i];
      if (best >= 0) begin
        m_y = best; m_asc = 1; m_vel = 20; m_fall = 0;
      end else if (m_y < m_min + fp) begin
        m_y = m_min; m_go = 1;
      end else begin
        m_y = m_y - fp; m_fall = fp;
      end
    end
    m_x = nx;
  endfunction

  task automatic cmp_model(input string tag);
    chk({tag, "_x"},   doodleX,   m_x);
    chk({tag, "_y"},   doodleY,   m_y);
    chk({tag, "_min"}, minY,      m_min);
    chk({tag, "_asc"}, ascending, m_asc);
    chk({tag, "_go"},  gameOver,  m_go);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; tick = 0; left = 0; right = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_x"},    doodleX,   200);
    chk({tag, "_y"},    doodleY,   10);
    chk({tag, "_min"},  minY,      0);
    chk({tag, "_asc"},  ascending, 1);
    chk({tag, "_busy"}, busy,      0);
    chk({tag, "_done"}, done,      0);
    chk({tag, "_go"},   gameOver,  0);
  endtask

  task automatic do_tick(input bit l, input bit r, input bit inj);
    int lat;
    int extra;
    bit got;
    @(negedge clk);
    left = l; right = r; tick = 1;
    @(posedge clk); #1;
    tick = 0;
    lat = 0; got = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      tick = inj && (c == 2);
      @(posedge clk); #1;
      if (c == 1) chk("busy_in_scan", busy, 1);
      if (done) begin got = 1; lat = c; end
    end
    tick = 0;
    chk("tick_latency", lat, 9);
    chk("busy_at_done", busy, 0);
    model_tick(l, r);
    cmp_model("tick");
    extra = 0;
    for (int c = 0; c < (inj ? 15 : 1); c++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    chk(inj ? "busy_tick_ignored" : "done_one_cycle", extra, 0);
  endtask

  task automatic dead_tick();
    int cnt = 0;
    @(negedge clk);
    tick = 1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      tick = 0;
      if (done) cnt++;
    end
    chk("dead_no_done", cnt, 0);
    chk("dead_busy", busy, 0);
    cmp_model("dead");
  endtask

  typedef struct {
    int     n;
    bit     l, r, inj;
    int     cfg;
    longint ex, ey, emin;
    bit     easc;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed sequence from reset; each row = n ticks then an absolute check
    tbl[0]  = '{1,  0, 0, 1, 0, 200, 30,  0,  1};
    tbl[1]  = '{19, 0, 0, 0, 0, 200, 220, 0,  0};
    tbl[2]  = '{1,  0, 0, 0, 0, 200, 219, 0,  0};
    tbl[3]  = '{4,  0, 0, 0, 0, 200, 205, 0,  0};
    tbl[4]  = '{1,  0, 0, 0, 1, 200, 200, 0,  1};
    tbl[5]  = '{1,  0, 0, 0, 0, 200, 220, 0,  1};
    tbl[6]  = '{19, 0, 0, 0, 0, 200, 410, 60, 0};
    tbl[7]  = '{49, 0, 1, 0, 2, 396, 365, 60, 0};
`ifdef DOODLE_WRAP_EN
    tbl[8]  = '{1,  0, 1, 0, 2, 0,   355, 60, 0};
    tbl[9]  = '{1,  1, 1, 0, 2, 0,   344, 60, 0};
    tbl[10] = '{1,  1, 0, 0, 2, 396, 332, 60, 0};
`else
    tbl[8]  = '{1,  0, 1, 0, 2, 399, 355, 60, 0};
    tbl[9]  = '{1,  1, 1, 0, 2, 399, 344, 60, 0};
    tbl[10] = '{1,  1, 0, 0, 2, 395, 332, 60, 0};
`endif

    set_cfg(0);
    do_reset();
    check_reset_vals("reset");

    for (int t = 0; t < 11; t++) begin
      set_cfg(tbl[t].cfg);
      for (int k = 0; k < tbl[t].n; k++)
        do_tick(tbl[t].l, tbl[t].r, tbl[t].inj && (k == 0));
      chk($sformatf("vec%0d_x", t),   doodleX,   tbl[t].ex);
      chk($sformatf("vec%0d_y", t),   doodleY,   tbl[t].ey);
      chk($sformatf("vec%0d_min", t), minY,      tbl[t].emin);
      chk($sformatf("vec%0d_asc", t), ascending, tbl[t].easc);
    end

    // Fall with no platforms until death, then ticks must be ignored
    set_cfg(0);
    for (int k = 0; k < 100 && !m_go; k++) do_tick(0, 0, 0);
    chk("death_gameover", gameOver, 1);
    chk("death_y_is_min", doodleY, minY);
    for (int k = 0; k < 3; k++) dead_tick();

    // Reset out of DEAD, one tick, then reset in the middle of a scan
    do_reset();
    check_reset_vals("reset_from_dead");
    do_tick(0, 1, 0);
    chk("post_reset_tick_y", doodleY, 30);
    begin
      int cnt = 0;
      @(negedge clk);
      tick = 1; left = 1; right = 0;
      @(posedge clk); #1;
      tick = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1;
      @(posedge clk); #1;
      reset = 0;
      model_reset();
      check_reset_vals("midscan_reset");
      for (int c = 0; c < 15; c++) begin
        @(posedge clk); #1;
        if (done) cnt++;
      end
      chk("midscan_no_done", cnt, 0);
    end

    // Random ticks with platforms scattered near the doodle
    for (int k = 0; k < 300; k++) begin
      if (m_go || $urandom_range(0, 59) == 0) do_reset();
      if ($urandom_range(0, 2) != 0) begin
        for (int i = 0; i < NB; i++) begin
          longint x, y;
          x = m_x - longint'($urandom_range(0, 60));
          y = m_y - longint'($urandom_range(0, 28)) + 3;
          set_slot(i, (x < 0) ? 0 : x, (y < 0) ? 0 : y, $urandom_range(0, 1) == 1);
        end
        drive_blocks();
      end
      do_tick($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
